// File: rtl/ecc8_pkg.sv
// ecc8_pkg: shared codeword layout and types for the 8-bit Hamming encoder/decoder pair
package ecc8_pkg;
  localparam int ECC8_CW_W = 12;
  localparam int P1  = 0;
  localparam int P2  = 1;
  localparam int D3  = 2;
  localparam int P4  = 3;
  localparam int D5  = 4;
  localparam int D6  = 5;
  localparam int D7  = 6;
  localparam int P8  = 7;
  localparam int D9  = 8;
  localparam int D10 = 9;
  localparam int D11 = 10;
  localparam int D12 = 11;
  typedef logic [7:0] ecc8_dat_t;
  typedef logic [ECC8_CW_W-1:0] ecc8_cw_t;
endpackage

// File: rtl/ecc_enc8_core.sv
// ecc_enc8_core: combinational 8-bit to 12-bit Hamming SEC encoder, optional parity disable
module ecc_enc8_core
  import ecc8_pkg::*;
(
  input  ecc8_dat_t in_dat,
  input  logic      in_dis,
  output ecc8_cw_t  out_cw
);
  // Scatter data into non-power-of-two positions, then fill parity unless disabled
  always_comb begin
    out_cw      = '0;
    out_cw[D3]  = in_dat[0];
    out_cw[D5]  = in_dat[1];
    out_cw[D6]  = in_dat[2];
    out_cw[D7]  = in_dat[3];
    out_cw[D9]  = in_dat[4];
    out_cw[D10] = in_dat[5];
    out_cw[D11] = in_dat[6];
    out_cw[D12] = in_dat[7];
    out_cw[P1]  = !in_dis & (in_dat[0] ^ in_dat[1] ^ in_dat[3] ^ in_dat[4] ^ in_dat[6]);
    out_cw[P2]  = !in_dis & (in_dat[0] ^ in_dat[2] ^ in_dat[3] ^ in_dat[5] ^ in_dat[6]);
    out_cw[P4]  = !in_dis & (in_dat[1] ^ in_dat[2] ^ in_dat[3] ^ in_dat[7]);
    out_cw[P8]  = !in_dis & (in_dat[4] ^ in_dat[5] ^ in_dat[6] ^ in_dat[7]);
  end
endmodule

// File: rtl/ecc_enc8_strm.sv
// ecc_enc8_strm: streaming Hamming encoder with output register + skid buffer; ECC_ENC8_ERRINJ_EN adds bit-flip injection
module ecc_enc8_strm
  import ecc8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [7:0]       in_dat,
  input  logic             in_dis,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [11:0]      out_dat,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt
`ifdef ECC_ENC8_ERRINJ_EN
  ,
  input  logic             inj_req,
  input  logic [3:0]       inj_pos,
  output logic             inj_busy
`endif
);
  logic             r_or_vld;
  ecc8_cw_t         r_or_dat;
  logic             r_sk_vld;
  ecc8_cw_t         r_sk_dat;
  logic [CNT_W-1:0] r_cnt;
  ecc8_cw_t         w_cw;
  ecc8_cw_t         w_cw_f;
  logic             w_acc;
  logic             w_drain;
  logic             w_out_fire;

  assign w_acc      = in_vld & !r_sk_vld;
  assign w_drain    = !r_or_vld | out_rdy;
  assign w_out_fire = r_or_vld & out_rdy;
  assign in_rdy     = !r_sk_vld;
  assign out_vld    = r_or_vld;
  assign out_dat    = r_or_dat;
  assign cnt        = r_cnt;

  ecc_enc8_core u_core (
    .in_dat (in_dat),
    .in_dis (in_dis),
    .out_cw (w_cw)
  );

`ifdef ECC_ENC8_ERRINJ_EN
  logic       r_inj_arm;
  logic [3:0] r_inj_pos;
  logic       w_arm;
  logic [3:0] w_pos;

  assign w_arm    = r_inj_arm | inj_req;
  assign w_pos    = inj_req ? inj_pos : r_inj_pos;
  assign w_cw_f   = (w_acc && w_arm && w_pos < 4'd12) ? w_cw ^ (ecc8_cw_t'(1) << w_pos) : w_cw;
  assign inj_busy = r_inj_arm;

  // Arm on request, disarm on the first accepted word (positions 12..15 just disarm)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inj_arm <= 1'b0;
      r_inj_pos <= '0;
    end else begin
      r_inj_arm <= w_arm & !w_acc;
      r_inj_pos <= w_pos;
    end
  end
`else
  assign w_cw_f = w_cw;
`endif

  // Output register refills from skid first to keep FIFO order; skid catches a word only under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_or_vld <= 1'b0;
      r_or_dat <= '0;
      r_sk_vld <= 1'b0;
    end else if (w_drain) begin
      r_or_vld <= r_sk_vld | w_acc;
      if (r_sk_vld) r_or_dat <= r_sk_dat;
      else if (w_acc) r_or_dat <= w_cw_f;
      r_sk_vld <= 1'b0;
    end else if (w_acc) begin
      r_sk_vld <= 1'b1;
    end
  end

  // Skid data needs no reset; its valid flag guards it
  always_ff @(posedge clk) begin
    if (!w_drain && w_acc) r_sk_dat <= w_cw_f;
  end

  // Saturating transfer counter; clear beats a coincident transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= cnt_clr ? '0 : (w_out_fire && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;
  end
endmodule

// File: tb/tb_ecc_enc8_strm.sv
// tb_ecc_enc8_strm: vector table, backpressure/reset sequences and random streaming against a Hamming model
module tb_ecc_enc8_strm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic [7:0]  in_dat = 8'h00;
  logic        in_dis = 1'b0;
  logic        out_rdy = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        in_rdy, out_vld, in_rdy4, out_vld4;
  logic [11:0] out_dat, out_dat4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;
`ifdef ECC_ENC8_ERRINJ_EN
  logic        inj_req = 1'b0;
  logic [3:0]  inj_pos = 4'd0;
  logic        inj_busy, inj_busy4;
`endif

  always #5 clk = ~clk;

  ecc_enc8_strm #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_dis(in_dis),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .cnt_clr(cnt_clr), .cnt(cnt)
`ifdef ECC_ENC8_ERRINJ_EN
    , .inj_req(inj_req), .inj_pos(inj_pos), .inj_busy(inj_busy)
`endif
  );

  ecc_enc8_strm #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy4), .in_dat(in_dat), .in_dis(in_dis),
    .out_vld(out_vld4), .out_rdy(out_rdy), .out_dat(out_dat4), .cnt_clr(cnt_clr), .cnt(cnt4)
`ifdef ECC_ENC8_ERRINJ_EN
    , .inj_req(inj_req), .inj_pos(inj_pos), .inj_busy(inj_busy4)
`endif
  );

  typedef struct {
    logic [7:0]  d;
    logic        dis;
    logic [11:0] cw;
  } vec_t;

  vec_t        vt[5];
  int          npass = 0;
  int          ntot = 0;
  logic [11:0] q[$];
  logic [7:0]  qd[$];
  int          e16 = 0;
  int          e4 = 0;
  bit          dec_chk = 1'b0;
  bit          m_arm = 1'b0;
  int          m_pos = 0;

  // Hamming rule: data fills non-power-of-two positions 1..12 in order; parity 2^b covers positions with bit b set
  function automatic logic [11:0] model_enc(input logic [7:0] d, input logic dis);
    logic [11:0] cw;
    int k;
    cw = '0;
    k = 0;
    for (int p = 1; p <= 12; p++) if ((p & (p - 1)) != 0) begin cw[p-1] = d[k]; k++; end
    if (!dis)
      for (int b = 0; b < 4; b++)
        for (int p = 1; p <= 12; p++)
          if (((p >> b) & 1) == 1 && p != (1 << b)) cw[(1<<b)-1] = cw[(1<<b)-1] ^ cw[p-1];
    return cw;
  endfunction

  task automatic check(input string n, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", n, got, exp);
  endtask

  // One clock: score handshakes seen before the edge, then advance to #1 after it
  task automatic step();
    logic [11:0] e;
    logic [7:0]  dd;
    logic [7:0]  di;
    int          s;
    int          k;
    bit          ifire;
    bit          ofire;
    ifire = in_vld && in_rdy;
    ofire = out_vld && out_rdy;
    e = model_enc(in_dat, in_dis);
`ifdef ECC_ENC8_ERRINJ_EN
    begin
      bit arm;
      int pos;
      arm = m_arm || inj_req;
      pos = inj_req ? int'(inj_pos) : m_pos;
      if (ifire && arm && pos < 12) e[pos] = ~e[pos];
      m_arm = arm && !ifire;
      m_pos = pos;
    end
`endif
    if (ifire) begin
      q.push_back(e);
      qd.push_back(in_dat);
    end
    if (ofire) begin
      if (q.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        di = qd.pop_front();
        check("out_dat", int'(out_dat), int'(e));
        check("out_dat4", int'(out_dat4), int'(e));
        if (dec_chk) begin
          s = 0;
          k = 0;
          dd = '0;
          for (int p = 1; p <= 12; p++) begin
            if (out_dat[p-1]) s = s ^ p;
            if ((p & (p - 1)) != 0) begin dd[k] = out_dat[p-1]; k++; end
          end
          check("dec_alarm", s, 0);
          check("dec_data", int'(dd), int'(di));
        end
      end
    end
    if (cnt_clr) begin e16 = 0; e4 = 0; end
    else if (ofire) begin
      if (e16 < 65535) e16++;
      if (e4 < 15) e4++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic dis);
    bit done;
    done = 1'b0;
    in_vld = 1'b1;
    in_dat = d;
    in_dis = dis;
    for (int i = 0; i < 20 && !done; i++) begin
      done = in_rdy;
      step();
    end
    if (!done) check("send_timeout", 0, 1);
    in_vld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && out_vld; i++) step();
    check("drained", int'(out_vld), 0);
  endtask

  initial begin
    int sent;
    bit fire;
    bit fin;
    vt[0] = '{8'h00, 1'b0, 12'h000};
    vt[1] = '{8'hFF, 1'b0, 12'hF77};
    vt[2] = '{8'h01, 1'b0, 12'h007};
    vt[3] = '{8'h80, 1'b0, 12'h888};
    vt[4] = '{8'hFF, 1'b1, 12'hF74};

    #1;
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_out_dat", int'(out_dat), 0);
    check("rst_in_rdy", int'(in_rdy), 1);
    check("rst_cnt", int'(cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1;
      in_dat = vt[i].d;
      in_dis = vt[i].dis;
      check("pre_vld", int'(out_vld), 0);
      step();
      in_vld = 1'b0;
      check("vec_vld", int'(out_vld), 1);
      check("vec_dat", int'(out_dat), int'(vt[i].cw));
      step();
      check("vec_cnt", int'(cnt), i + 1);
    end
    in_dis = 1'b0;

    out_rdy = 1'b0;
    in_vld = 1'b1;
    in_dat = 8'hA1;
    step();
    in_dat = 8'hB2;
    step();
    check("bp_in_rdy", int'(in_rdy), 0);
    in_dat = 8'hC3;
    step();
    step();
    check("bp_in_rdy_hold", int'(in_rdy), 0);
    check("bp_occupancy", q.size(), 2);
    check("bp_head", int'(out_dat), int'(model_enc(8'hA1, 1'b0)));
    out_rdy = 1'b1;
    fin = 1'b0;
    for (int i = 0; i < 10 && !fin; i++) begin
      fin = in_rdy;
      step();
    end
    in_vld = 1'b0;
    check("bp_c_accepted", int'(fin), 1);
    drain();
    check("bp_empty", q.size(), 0);

    dec_chk = 1'b1;
    sent = 0;
    fin = 1'b0;
    for (int c = 0; c < 5000 && !fin; c++) begin
      if (!in_vld && sent < 256 && $urandom_range(3) != 0) begin
        in_vld = 1'b1;
        in_dat = 8'($urandom);
      end
      out_rdy = $urandom_range(2) != 0;
      fire = in_vld && in_rdy;
      step();
      if (fire) begin sent++; in_vld = 1'b0; end
      fin = sent == 256 && q.size() == 0 && !out_vld;
    end
    in_vld = 1'b0;
    dec_chk = 1'b0;
    check("stream_done", int'(fin), 1);
    check("stream_cnt", int'(cnt), e16);
    check("stream_cnt_total", int'(cnt), 5 + 3 + 256);
    check("sat_cnt4", int'(cnt4), 15);

    out_rdy = 1'b0;
    send(8'h5A, 1'b0);
    check("clr_pre_vld", int'(out_vld), 1);
    out_rdy = 1'b1;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_cnt", int'(cnt), 0);
    check("clr_cnt4", int'(cnt4), 0);
    check("clr_model", int'(cnt), e16);

`ifdef ECC_ENC8_ERRINJ_EN
    out_rdy = 1'b1;
    inj_req = 1'b1;
    inj_pos = 4'd5;
    step();
    inj_req = 1'b0;
    check("inj_busy_armed", int'(inj_busy), 1);
    send(8'h00, 1'b0);
    check("inj_flip", int'(out_dat), 12'h020);
    check("inj_busy_clear", int'(inj_busy), 0);
    step();
    inj_req = 1'b1;
    inj_pos = 4'd13;
    step();
    inj_req = 1'b0;
    send(8'h00, 1'b0);
    check("inj_noflip", int'(out_dat), 12'h000);
    check("inj_busy_noflip", int'(inj_busy), 0);
    step();
`endif

    out_rdy = 1'b0;
    in_vld = 1'b1;
    in_dat = 8'h11;
    step();
    in_dat = 8'h22;
    step();
    in_vld = 1'b0;
    check("full_in_rdy", int'(in_rdy), 0);
    check("full_out_vld", int'(out_vld), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_vld", int'(out_vld), 0);
    check("mid_rst_in_rdy", int'(in_rdy), 1);
    check("mid_rst_cnt", int'(cnt), 0);
    check("mid_rst_in_rdy4", int'(in_rdy4), 1);
    check("mid_rst_out_vld4", int'(out_vld4), 0);
    q.delete();
    qd.delete();
    e16 = 0;
    e4 = 0;
    m_arm = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_vld", int'(out_vld), 0);
    out_rdy = 1'b1;
    send(8'h3C, 1'b0);
    drain();
    check("post_rst_cnt", int'(cnt), 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
